// File: rtl/uart_rx_unit.sv
// uart_rx_unit
// UART serial receiver with its own oversampling baud-tick generator.
// The rx line is sampled OVERSAMPLE times per bit. Each frame is one start bit,
// DATA_BITS data bits sent LSB first, and one stop bit. Every byte that is
// received correctly is presented with a one-clk done strobe.
//
// Ports
//   clk       system clock; all logic runs on the rising edge
//   PRESETn   synchronous active-low reset of the whole block
//   rx_rst    synchronous active-high reset of the receiver only;
//             the baud generator keeps running
//   rx_en     receiver enable
//   rx        asynchronous serial input, idle high
//   div_in    tick divisor override; 0 selects the default divisor
//   s_tick    oversample tick, a one-clk pulse
//   data_out  last correctly received byte
//   rx_done   one-clk pulse when a valid frame completes
//   rx_error  framing error flag
//   rx_busy   high while a frame is being received
module uart_rx_unit #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_RATE  = 9600,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 PRESETn,
    input  logic                 rx_rst,
    input  logic                 rx_en,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     div_in,
    output logic                 s_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 rx_error,
    output logic                 rx_busy
);

    localparam int DEF_DIV_I = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEF_DIV_I);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    logic [DIV_W-1:0]     div_s;
    logic [DIV_W-1:0]     div_m1_s;
    logic [DIV_W-1:0]     baud_cnt_r;
    logic                 sync1_r;
    logic                 rxs_r;
    state_t               state_r, state_n;
    logic [TW-1:0]        tcnt_r, tcnt_n;
    logic [BW-1:0]        bcnt_r, bcnt_n;
    logic [DATA_BITS-1:0] shreg_r, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 done_n;
    logic                 err_n;
    logic                 busy_n;

    assign div_s    = (div_in != {DIV_W{1'b0}}) ? div_in : DEF_DIV;
    assign div_m1_s = div_s - {{(DIV_W-1){1'b0}}, 1'b1};

    // Baud counter. Using >= rather than == means that when the divisor shrinks
    // below the current count, the generator ticks on the next clk and wraps.
    always_ff @(posedge clk) begin
        if (!PRESETn) begin
            baud_cnt_r <= {DIV_W{1'b0}};
            s_tick     <= 1'b0;
        end else if (baud_cnt_r >= div_m1_s) begin
            baud_cnt_r <= {DIV_W{1'b0}};
            s_tick     <= 1'b1;
        end else begin
            baud_cnt_r <= baud_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            s_tick     <= 1'b0;
        end
    end

    // Two-flop synchronizer for the asynchronous rx line. It resets to the
    // idle level.
    always_ff @(posedge clk) begin
        if (!PRESETn) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx;
            rxs_r   <= sync1_r;
        end
    end

    // Receiver state and output registers. rx_rst clears the same registers
    // as PRESETn.
    always_ff @(posedge clk) begin
        if (!PRESETn || rx_rst) begin
            state_r  <= IDLE;
            tcnt_r   <= {TW{1'b0}};
            bcnt_r   <= {BW{1'b0}};
            shreg_r  <= {DATA_BITS{1'b0}};
            data_out <= {DATA_BITS{1'b0}};
            rx_done  <= 1'b0;
            rx_error <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            state_r  <= state_n;
            tcnt_r   <= tcnt_n;
            bcnt_r   <= bcnt_n;
            shreg_r  <= shreg_n;
            data_out <= data_n;
            rx_done  <= done_n;
            rx_error <= err_n;
            rx_busy  <= busy_n;
        end
    end

    // Next-state and next-output logic for the frame receiver.
    always_comb begin
        state_n = state_r;
        tcnt_n  = tcnt_r;
        bcnt_n  = bcnt_r;
        shreg_n = shreg_r;
        data_n  = data_out;
        done_n  = 1'b0;
        err_n   = rx_error;
        if ((state_r != IDLE) && !rx_en) begin
            // Disabling the receiver mid-frame drops the frame silently.
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rx_en && !rxs_r) begin
                        state_n = START;
                        tcnt_n  = {TW{1'b0}};
                    end else begin
                        state_n = IDLE;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tcnt_r == T_MID) begin
                            if (!rxs_r) begin
                                // Mid start bit is still low: the frame is real
                                // and bit sampling is aligned from this point.
                                state_n = DATA;
                                tcnt_n  = {TW{1'b0}};
                                bcnt_n  = {BW{1'b0}};
                                err_n   = 1'b0;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            tcnt_n = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tcnt_n = tcnt_r;
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tcnt_r == T_END) begin
                            shreg_n = {rxs_r, shreg_r[DATA_BITS-1:1]};
                            tcnt_n  = {TW{1'b0}};
                            bcnt_n  = bcnt_r + {{(BW-1){1'b0}}, 1'b1};
                            if (bcnt_r == B_LAST) begin
                                state_n = STOP;
                            end else begin
                                state_n = DATA;
                            end
                        end else begin
                            tcnt_n = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tcnt_n = tcnt_r;
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tcnt_r == T_END) begin
                            if (rxs_r) begin
                                data_n  = shreg_r;
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end else begin
                                err_n   = 1'b1;
                                state_n = ERR;
                            end
                        end else begin
                            tcnt_n = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tcnt_n = tcnt_r;
                    end
                end
                ERR: begin
                    if (rxs_r) begin
                        state_n = IDLE;
                    end else begin
                        state_n = ERR;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        busy_n = (state_n == START) || (state_n == DATA) || (state_n == STOP);
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
module tb_uart_rx_unit;

    logic        clk = 1'b0;
    logic        PRESETn;
    logic        rx_rst;
    logic        rx_en;
    logic        rx;
    logic [15:0] div_in;
    logic        s_tick;
    logic [7:0]  data_out;
    logic        rx_done;
    logic        rx_error;
    logic        rx_busy;

    uart_rx_unit dut (
        .clk      (clk),
        .PRESETn  (PRESETn),
        .rx_rst   (rx_rst),
        .rx_en    (rx_en),
        .rx       (rx),
        .div_in   (div_in),
        .s_tick   (s_tick),
        .data_out (data_out),
        .rx_done  (rx_done),
        .rx_error (rx_error),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt  = 0;
    int err_cyc   = 0;
    int busy_cyc  = 0;
    int both_cyc  = 0;
    logic [7:0] done_q[$];

    always @(posedge clk) cyc++;

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_q.push_back(data_out);
        end
        if (rx_error) err_cyc++;
        if (rx_busy) busy_cyc++;
        if (rx_done && rx_error) both_cyc++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int cpb);
        rx = 1'b0;
        wait_clks(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(cpb);
        end
        rx = stop;
        wait_clks(cpb);
        rx = 1'b1;
    endtask

    task automatic wait_tick(input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (s_tick) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        rx_rst  = 1'b0;
        rx_en   = 1'b1;
        rx      = 1'b1;
        div_in  = 16'd0;
        wait_clks(3);
        @(negedge clk);
        total++; if (s_tick !== 1'b0) begin bad++; $display("FAIL reset_s_tick: got %b expected 0", s_tick); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", data_out); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", rx_done); end
        total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b expected 0", rx_error); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        PRESETn = 1'b1;
        wait_clks(1);
    endtask

    task automatic measure_period(input string name, input int expected);
        int t0, t1, t2;
        bit ok0, ok1, ok2;
        wait_tick(2000, t0, ok0);
        wait_tick(2000, t1, ok1);
        wait_tick(2000, t2, ok2);
        total++;
        if (!(ok0 && ok1 && ok2)) begin
            bad++; $display("FAIL %s_timeout: got no tick within bound, expected ticks", name);
        end else begin
            if ((t1 - t0) !== expected) begin bad++; $display("FAIL %s_period1: got %0d expected %0d", name, t1 - t0, expected); end
            total++;
            if ((t2 - t1) !== expected) begin bad++; $display("FAIL %s_period2: got %0d expected %0d", name, t2 - t1, expected); end
        end
    endtask

    task automatic test_default_period();
        measure_period("default_div", 651);
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL idle_done: got %0d expected 0", done_cnt); end
        total++; if (busy_cyc !== 0) begin bad++; $display("FAIL idle_busy: got %0d expected 0", busy_cyc); end
        total++; if (err_cyc !== 0) begin bad++; $display("FAIL idle_error: got %0d expected 0", err_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int b, e, bu;
        exp_b[0] = 8'h55; exp_b[1] = 8'hF1; exp_b[2] = 8'hA3;
        div_in = 16'd4;
        wait_clks(20);
        b = done_cnt; e = err_cyc; bu = busy_cyc;
        for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1, 64);
        wait_clks(128);
        total++; if ((done_cnt - b) !== 3) begin bad++; $display("FAIL b2b_count: got %0d expected 3", done_cnt - b); end
        for (int i = 0; i < 3; i++) begin
            if (b + i < done_cnt) begin
                total++;
                if (done_q[b + i] !== exp_b[i]) begin bad++; $display("FAIL b2b_data%0d: got %h expected %h", i, done_q[b + i], exp_b[i]); end
            end
        end
        total++; if ((err_cyc - e) !== 0) begin bad++; $display("FAIL b2b_error: got %0d error cycles expected 0", err_cyc - e); end
        total++; if ((busy_cyc - bu) < 1700) begin bad++; $display("FAIL b2b_busy: got %0d busy cycles expected >=1700", busy_cyc - bu); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_framing();
        int b;
        b = done_cnt;
        send_byte(8'h3C, 1'b0, 64);
        wait_clks(64);
        total++; if ((done_cnt - b) !== 0) begin bad++; $display("FAIL frm_done: got %0d expected 0", done_cnt - b); end
        total++; if (rx_error !== 1'b1) begin bad++; $display("FAIL frm_error: got %b expected 1", rx_error); end
        total++; if (data_out !== 8'hA3) begin bad++; $display("FAIL frm_data_kept: got %h expected a3", data_out); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL frm_busy: got %b expected 0", rx_busy); end
        send_byte(8'h12, 1'b1, 64);
        wait_clks(64);
        total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL frm_error_clear: got %b expected 0", rx_error); end
        total++; if ((done_cnt - b) !== 1) begin bad++; $display("FAIL frm_next_count: got %0d expected 1", done_cnt - b); end
        total++; if (data_out !== 8'h12) begin bad++; $display("FAIL frm_next_data: got %h expected 12", data_out); end
    endtask

    task automatic test_glitch();
        int b, bu;
        b = done_cnt; bu = busy_cyc;
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(64);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b expected 0", rx_busy); end
        total++; if ((done_cnt - b) !== 0) begin bad++; $display("FAIL glitch_done: got %0d expected 0", done_cnt - b); end
        total++; if ((busy_cyc - bu) > 48) begin bad++; $display("FAIL glitch_busy_len: got %0d expected <=48", busy_cyc - bu); end
        total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL glitch_error: got %b expected 0", rx_error); end
    endtask

    task automatic test_soft_reset();
        int b;
        b = done_cnt;
        rx = 1'b0; wait_clks(64);
        rx = 1'b1; wait_clks(64);
        rx = 1'b1; wait_clks(64);
        rx = 1'b0; wait_clks(28);
        rx = 1'b1; wait_clks(4);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL srst_pre_busy: got %b expected 1", rx_busy); end
        rx_rst = 1'b1;
        wait_clks(1);
        rx_rst = 1'b0;
        @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL srst_busy: got %b expected 0", rx_busy); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL srst_data: got %h expected 00", data_out); end
        wait_clks(128);
        total++; if ((done_cnt - b) !== 0) begin bad++; $display("FAIL srst_done: got %0d expected 0", done_cnt - b); end
        send_byte(8'hC3, 1'b1, 64);
        wait_clks(64);
        total++; if ((done_cnt - b) !== 1) begin bad++; $display("FAIL srst_next_count: got %0d expected 1", done_cnt - b); end
        total++; if (data_out !== 8'hC3) begin bad++; $display("FAIL srst_next_data: got %h expected c3", data_out); end
    endtask

    task automatic test_div10();
        int b;
        div_in = 16'd10;
        measure_period("div10", 10);
        wait_clks(1);
        b = done_cnt;
        send_byte(8'h9A, 1'b1, 160);
        wait_clks(160);
        total++; if ((done_cnt - b) !== 1) begin bad++; $display("FAIL div10_count: got %0d expected 1", done_cnt - b); end
        total++; if (data_out !== 8'h9A) begin bad++; $display("FAIL div10_data: got %h expected 9a", data_out); end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_soft_reset();
        test_div10();
        total++; if (both_cyc !== 0) begin bad++; $display("FAIL done_and_error: got %0d cycles expected 0", both_cyc); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
UART serial receiver with an integrated oversampling baud-tick generator. It samples the asynchronous `rx` line at OVERSAMPLE ticks per bit, recovers frames of 1 start bit, DATA_BITS data bits (LSB first) and 1 stop bit, and presents each byte with a one-cycle done strobe. It sits behind the APB UART register block, which supplies enable, soft reset and the divisor override, and consumes data and status.

Parameters:
- DATA_BITS, 8: data bits per frame.
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- OVERSAMPLE, 16: ticks per bit period.
- BAUD_RATE, 9600: default baud rate.
- DIV_W, 16: width of the divisor override.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- PRESETn  in  1  reset, synchronous, active-low; resets the whole block.
- rx_rst  in  1  synchronous active-high soft reset of the receiver only; the baud generator keeps running.
- rx_en  in  1  receiver enable.
- rx  in  1  serial input; idle high.
- div_in  in  DIV_W  tick divisor override; 0 selects the default divisor.
- s_tick  out  1  oversample tick, a one-clk pulse.
- data_out  out  DATA_BITS  last correctly received byte.
- rx_done  out  1  one-clk pulse when a valid frame completes.
- rx_error  out  1  framing error flag.
- rx_busy  out  1  high while a frame is being received.

Behaviour:
- Reset: PRESETn=0 at a clk edge clears everything: data_out=0, rx_done=0, rx_error=0, rx_busy=0, s_tick=0, baud counter=0, FSM=IDLE.
- rx_rst=1 has the same effect on receiver state and outputs only. PRESETn has priority over rx_rst.
- Divisor: DIV = div_in if div_in != 0; otherwise CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated. The default evaluates to 651.
- Baud counter: counts 0..DIV-1. s_tick=1 for exactly one clk when the count equals DIV-1, then the counter wraps to 0.
- Divisor change: if the count is already at or above the new DIV-1, the generator ticks on the next clk and wraps.
- Input synchronizer: rx passes through a 2-flop synchronizer, reset to 1. The FSM uses only the synchronized value (rxs).
- FSM states are IDLE, START, DATA, STOP and ERR. The tick counter tcnt counts s_tick pulses within a bit; the bit counter bcnt counts data bits.
- IDLE:
  - When rx_en=1 and rxs=0, go to START with tcnt=0.
  - rx_busy=0.
- START:
  - On each tick, tcnt++.
  - When tcnt reaches OVERSAMPLE/2-1 (7), i.e. mid start bit: if rxs=0, go to DATA with tcnt=0, bcnt=0, and clear rx_error. Otherwise the low pulse was a glitch; return to IDLE.
- DATA:
  - On each tick, when tcnt=OVERSAMPLE-1, sample rxs into the shift register MSB and shift right (LSB first), set tcnt=0 and increment bcnt.
  - After DATA_BITS samples, go to STOP.
- STOP: when tcnt=OVERSAMPLE-1, sample rxs.
  - If rxs=1: data_out <= shift register; rx_done=1 for one clk; go to IDLE.
  - If rxs=0: rx_error <= 1; data_out is unchanged; rx_done stays 0; go to ERR.
- ERR: wait for rxs=1, then go to IDLE. rx_error stays high until the next valid start bit, rx_rst, or PRESETn.
- rx_busy=1 in START, DATA and STOP; it is 0 in IDLE and ERR.
- Disable mid-frame: rx_en=0 in any non-IDLE state aborts to IDLE on the next clk, with no done and no error.
- Sampling points: the stop bit is sampled mid-bit, so a start bit that immediately follows it is caught. Back-to-back frames with no idle gap must be received.
- rx_done and rx_error never assert in the same cycle.

Test Plan:
- Reset, div_in=0, rx idle high for 32 ticks -> s_tick period is 651 clks; all outputs are 0.
- Send 0x55, 0xF1, 0xA3 back-to-back, 16 ticks per bit -> three rx_done pulses with data_out 0x55, 0xF1, 0xA3; rx_error=0 throughout; rx_busy high during each frame.
- Send 0x3C with stop bit=0 -> no rx_done; rx_error=1; data_out stays 0xA3. Then a valid 0x12 -> rx_error clears at the start bit and rx_done shows 0x12.
- Pull rx low for 4 ticks, then high -> FSM returns to IDLE; no rx_busy beyond the glitch; no done.
- Assert rx_rst mid-DATA of a frame -> rx_busy=0 next clk; no done; the next full frame 0xC3 is received correctly.
- Set div_in=10 -> s_tick every 10 clks; a byte 0x9A sent at 160 clks per bit is received correctly.
